// File: rtl/alu_reservation_station.sv
// ALU reservation station: an age-ordered collapsing queue sitting after dispatch.
// Entry 0 is always the oldest. Each entry waits until both source operands are valid,
// snooping the CDB for producer tags. The oldest ready entry issues, one per cycle.
//
// Optional build macro: ALU_RS_WAKEUP_ISSUE_EN
//   When defined, an operand whose tag is on the CDB this cycle counts as ready for
//   select, and cdb_value is forwarded straight onto the issue operand.
//   When undefined, select uses only the registered ready bits, so a woken entry
//   issues one cycle after the broadcast.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge when valid and
// ready are both high in the preceding cycle. Valid never depends on ready in the
// same direction. alloc_ready depends only on registered occupancy. issue_valid
// depends only on entry state and the current CDB inputs.
module alu_reservation_station #(
  parameter int XLEN      = 32,
  parameter int RS_SIZE   = 8,
  parameter int ROB_TAG_W = 6,
  parameter int CNT_W     = $clog2(RS_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [3:0]           alloc_alu_op,
  input  logic [ROB_TAG_W-1:0] alloc_rob_tag,
  input  logic                 alloc_src1_rdy,
  input  logic                 alloc_src2_rdy,
  input  logic [ROB_TAG_W-1:0] alloc_src1_tag,
  input  logic [ROB_TAG_W-1:0] alloc_src2_tag,
  input  logic [XLEN-1:0]      alloc_src1_val,
  input  logic [XLEN-1:0]      alloc_src2_val,
  input  logic [XLEN-1:0]      alloc_imm,
  input  logic                 alloc_use_imm,
  input  logic                 cdb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [3:0]           issue_alu_op,
  output logic [XLEN-1:0]      issue_op_a,
  output logic [XLEN-1:0]      issue_op_b,
  output logic [ROB_TAG_W-1:0] issue_rob_tag,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           op;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 rdy1;
    logic [ROB_TAG_W-1:0] tag1;
    logic [XLEN-1:0]      val1;
    logic                 rdy2;
    logic [ROB_TAG_W-1:0] tag2;
    logic [XLEN-1:0]      val2;
  } entry_t;

  entry_t             ent_q [RS_SIZE];  // registered entries, index 0 oldest
  entry_t             ent_w [RS_SIZE];  // entries with this cycle's CDB wakeup applied
  entry_t             ent_n [RS_SIZE];  // next-state after collapse and allocation
  entry_t             new_ent;
  entry_t             sel_ent;
  logic [CNT_W-1:0]   occ_q;
  logic [CNT_W-1:0]   occ_n;
  logic [CNT_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [RS_SIZE-1:0] match1;
  logic [RS_SIZE-1:0] match2;
  logic [RS_SIZE-1:0] rdy_vec;
  logic               alloc_fire;
  logic               issue_fire;
  logic               new_match1;
  logic               new_match2;

  // CDB wakeup: waiting operands whose producer tag is broadcast become ready
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      match1[i] = cdb_valid && ent_q[i].valid && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag);
      match2[i] = cdb_valid && ent_q[i].valid && !ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag);
      ent_w[i] = ent_q[i];
      if (match1[i]) begin
        ent_w[i].rdy1 = 1'b1;
        ent_w[i].val1 = cdb_value;
      end
      if (match2[i]) begin
        ent_w[i].rdy2 = 1'b1;
        ent_w[i].val2 = cdb_value;
      end
    end
  end

  // Per-entry readiness for select
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_WAKEUP_ISSUE_EN
      rdy_vec[i] = ent_q[i].valid && (ent_q[i].rdy1 || match1[i]) && (ent_q[i].rdy2 || match2[i]);
`else
      rdy_vec[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
    end
  end

  // Oldest-first select: lowest ready index wins
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rdy_vec[i] && !sel_found) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_ent     = ent_q[sel_idx];
  assign issue_valid = |rdy_vec;
  assign issue_fire  = issue_valid && issue_ready;
  assign alloc_ready = (occ_q < CNT_W'(RS_SIZE));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign alloc_idx   = occ_q - CNT_W'(issue_fire);
  assign occupancy   = occ_q;

  // Issue payload from the selected entry, zero when nothing is ready
  always_comb begin
    issue_alu_op  = '0;
    issue_op_a    = '0;
    issue_op_b    = '0;
    issue_rob_tag = '0;
    if (issue_valid) begin
      issue_alu_op  = sel_ent.op;
      issue_rob_tag = sel_ent.rob_tag;
`ifdef ALU_RS_WAKEUP_ISSUE_EN
      issue_op_a    = sel_ent.rdy1 ? sel_ent.val1 : cdb_value;
      issue_op_b    = sel_ent.rdy2 ? sel_ent.val2 : cdb_value;
`else
      issue_op_a    = sel_ent.val1;
      issue_op_b    = sel_ent.val2;
`endif
    end
  end

  // Incoming entry, capturing a same-cycle CDB broadcast for waiting sources
  always_comb begin
    new_match1      = cdb_valid && !alloc_src1_rdy && (alloc_src1_tag == cdb_tag);
    new_match2      = cdb_valid && !alloc_use_imm && !alloc_src2_rdy && (alloc_src2_tag == cdb_tag);
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = alloc_alu_op;
    new_ent.rob_tag = alloc_rob_tag;
    new_ent.tag1    = alloc_src1_tag;
    new_ent.rdy1    = alloc_src1_rdy || new_match1;
    new_ent.val1    = alloc_src1_rdy ? alloc_src1_val : (new_match1 ? cdb_value : '0);
    new_ent.tag2    = alloc_src2_tag;
    if (alloc_use_imm) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = alloc_imm;
    end else begin
      new_ent.rdy2 = alloc_src2_rdy || new_match2;
      new_ent.val2 = alloc_src2_rdy ? alloc_src2_val : (new_match2 ? cdb_value : '0);
    end
  end

  // Next state: collapse above the issued slot, then drop the new entry at the top
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_n[i] = ent_w[i];
    end
    for (int i = 0; i < RS_SIZE - 1; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) begin
        ent_n[i] = ent_w[i + 1];
      end
    end
    if (issue_fire) begin
      ent_n[RS_SIZE-1].valid = 1'b0;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (alloc_fire && (i == int'(alloc_idx))) begin
        ent_n[i] = new_ent;
      end
    end
    occ_n = occ_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
  end

  // State update: reset clears everything, flush drops valid entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_n[i];
      end
      occ_q <= occ_n;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_alu_reservation_station;
  localparam int XLEN = 32;
  localparam int RS_SIZE = 8;
  localparam int TW = 6;
  localparam int CNT_W = 4;
`ifdef ALU_RS_WAKEUP_ISSUE_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk, rst, flush;
  logic alloc_valid, alloc_ready;
  logic [3:0] alloc_alu_op;
  logic [TW-1:0] alloc_rob_tag;
  logic alloc_src1_rdy, alloc_src2_rdy;
  logic [TW-1:0] alloc_src1_tag, alloc_src2_tag;
  logic [XLEN-1:0] alloc_src1_val, alloc_src2_val, alloc_imm;
  logic alloc_use_imm;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic issue_valid, issue_ready;
  logic [3:0] issue_alu_op;
  logic [XLEN-1:0] issue_op_a, issue_op_b;
  logic [TW-1:0] issue_rob_tag;
  logic [CNT_W-1:0] occupancy;

  alu_reservation_station #(.XLEN(XLEN), .RS_SIZE(RS_SIZE), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_alu_op(alloc_alu_op), .alloc_rob_tag(alloc_rob_tag),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
    .alloc_imm(alloc_imm), .alloc_use_imm(alloc_use_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_op(issue_alu_op), .issue_op_a(issue_op_a), .issue_op_b(issue_op_b),
    .issue_rob_tag(issue_rob_tag), .occupancy(occupancy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending instructions, oldest at the front
  typedef struct {
    logic [3:0]      op;
    logic [TW-1:0]   rob_tag;
    bit              r1;
    logic [TW-1:0]   t1;
    logic [XLEN-1:0] v1;
    bit              r2;
    logic [TW-1:0]   t2;
    logic [XLEN-1:0] v2;
  } m_ent_t;
  m_ent_t mq[$];

  function automatic bit src_ok(bit r, logic [TW-1:0] t);
    return r || (FWD && cdb_valid && (t == cdb_tag));
  endfunction

  task automatic model_expect(output bit e_ar, output int e_occ, output bit e_iv,
                              output logic [3:0] e_op, output logic [XLEN-1:0] e_a,
                              output logic [XLEN-1:0] e_b, output logic [TW-1:0] e_tag,
                              output int e_sel);
    e_ar = (mq.size() < RS_SIZE);
    e_occ = mq.size();
    e_iv = 1'b0; e_op = '0; e_a = '0; e_b = '0; e_tag = '0; e_sel = -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (!e_iv && src_ok(mq[k].r1, mq[k].t1) && src_ok(mq[k].r2, mq[k].t2)) begin
        e_iv = 1'b1;
        e_sel = k;
        e_op = mq[k].op;
        e_tag = mq[k].rob_tag;
        e_a = mq[k].r1 ? mq[k].v1 : cdb_value;
        e_b = mq[k].r2 ? mq[k].v2 : cdb_value;
      end
    end
  endtask

  task automatic check_model();
    bit ar, iv; int occ, sel; logic [3:0] op; logic [XLEN-1:0] a, b; logic [TW-1:0] tg;
    model_expect(ar, occ, iv, op, a, b, tg, sel);
    chk("alloc_ready", 64'(alloc_ready), 64'(ar));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("issue_valid", 64'(issue_valid), 64'(iv));
    chk("issue_alu_op", 64'(issue_alu_op), 64'(op));
    chk("issue_op_a", 64'(issue_op_a), 64'(a));
    chk("issue_op_b", 64'(issue_op_b), 64'(b));
    chk("issue_rob_tag", 64'(issue_rob_tag), 64'(tg));
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic model_update();
    bit ar, iv, afire; int occ, sel; logic [3:0] op; logic [XLEN-1:0] a, b; logic [TW-1:0] tg;
    m_ent_t ne, e;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    model_expect(ar, occ, iv, op, a, b, tg, sel);
    afire = alloc_valid && ar;
    ne.op = alloc_alu_op;
    ne.rob_tag = alloc_rob_tag;
    ne.t1 = alloc_src1_tag;
    ne.r1 = alloc_src1_rdy || (cdb_valid && alloc_src1_tag == cdb_tag);
    ne.v1 = alloc_src1_rdy ? alloc_src1_val : cdb_value;
    ne.t2 = alloc_src2_tag;
    if (alloc_use_imm) begin
      ne.r2 = 1'b1;
      ne.v2 = alloc_imm;
    end else begin
      ne.r2 = alloc_src2_rdy || (cdb_valid && alloc_src2_tag == cdb_tag);
      ne.v2 = alloc_src2_rdy ? alloc_src2_val : cdb_value;
    end
    for (int k = 0; k < mq.size(); k++) begin
      e = mq[k];
      if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_value; end
      if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_value; end
      mq[k] = e;
    end
    if (iv && issue_ready) mq.delete(sel);
    if (afire) mq.push_back(ne);
  endtask

  // One clock: sample outputs shortly after the falling edge, then advance
  task automatic cycle(input bit use_model);
    #1;
    if (use_model) check_model();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic set_idle();
    rst = 0; flush = 0; alloc_valid = 0; alloc_alu_op = 0; alloc_rob_tag = 0;
    alloc_src1_rdy = 0; alloc_src2_rdy = 0; alloc_src1_tag = 0; alloc_src2_tag = 0;
    alloc_src1_val = 0; alloc_src2_val = 0; alloc_imm = 0; alloc_use_imm = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; issue_ready = 0;
  endtask

  task automatic drive_alloc(input logic [3:0] op, input logic [TW-1:0] tg,
                             input bit r1, input logic [TW-1:0] t1, input logic [XLEN-1:0] v1,
                             input bit r2, input logic [TW-1:0] t2, input logic [XLEN-1:0] v2);
    alloc_valid = 1; alloc_alu_op = op; alloc_rob_tag = tg; alloc_use_imm = 0;
    alloc_src1_rdy = r1; alloc_src1_tag = t1; alloc_src1_val = v1;
    alloc_src2_rdy = r2; alloc_src2_tag = t2; alloc_src2_val = v2;
  endtask

  // Directed vector table
  typedef struct {
    bit rs, fl, av; logic [3:0] op; logic [TW-1:0] tg;
    bit r1; logic [TW-1:0] t1; logic [XLEN-1:0] v1;
    bit r2; logic [TW-1:0] t2; logic [XLEN-1:0] v2;
    bit cv; logic [TW-1:0] ct; logic [XLEN-1:0] cval; bit ir;
    bit e_ar; logic [CNT_W-1:0] e_occ; bit e_iv; logic [3:0] e_op;
    logic [XLEN-1:0] e_a, e_b; logic [TW-1:0] e_tag;
  } vec_t;

  function automatic vec_t mk(bit rs, bit fl, bit av, logic [3:0] op, logic [TW-1:0] tg,
      bit r1, logic [TW-1:0] t1, logic [XLEN-1:0] v1, bit r2, logic [TW-1:0] t2,
      logic [XLEN-1:0] v2, bit cv, logic [TW-1:0] ct, logic [XLEN-1:0] cval, bit ir,
      bit ear, logic [CNT_W-1:0] eocc, bit eiv, logic [3:0] eop, logic [XLEN-1:0] ea,
      logic [XLEN-1:0] eb, logic [TW-1:0] etag);
    vec_t v;
    v.rs = rs; v.fl = fl; v.av = av; v.op = op; v.tg = tg;
    v.r1 = r1; v.t1 = t1; v.v1 = v1; v.r2 = r2; v.t2 = t2; v.v2 = v2;
    v.cv = cv; v.ct = ct; v.cval = cval; v.ir = ir;
    v.e_ar = ear; v.e_occ = eocc; v.e_iv = eiv; v.e_op = eop; v.e_a = ea; v.e_b = eb; v.e_tag = etag;
    return v;
  endfunction

  vec_t tbl[15];
  logic [TW-1:0] got[$];

  initial begin
    bit accepted, hs;
    int n;

    // Directed table (one row per cycle; expectations are the outputs seen in that cycle)
    tbl[0]  = mk(0,0,1, 0, 5, 1,0,10, 1,0,20, 0,0,0, 0,   1,0,0, 0,0,0,0);
    tbl[1]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 1,   1,1,1, 0,10,20,5);
    tbl[2]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 0,   1,0,0, 0,0,0,0);
    tbl[3]  = mk(0,0,1, 1, 1, 0,9,0,  1,0,3,  0,0,0, 1,   1,0,0, 0,0,0,0);
    tbl[4]  = mk(0,0,1, 2, 2, 1,0,7,  1,0,8,  0,0,0, 1,   1,1,0, 0,0,0,0);
    tbl[5]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 1,   1,2,1, 2,7,8,2);
`ifdef ALU_RS_WAKEUP_ISSUE_EN
    tbl[6]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  1,9,32'h55, 1, 1,1,1, 1,32'h55,3,1);
    tbl[7]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 1,   1,0,0, 0,0,0,0);
`else
    tbl[6]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  1,9,32'h55, 1, 1,1,0, 0,0,0,0);
    tbl[7]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 1,   1,1,1, 1,32'h55,3,1);
`endif
    tbl[8]  = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 0,   1,0,0, 0,0,0,0);
    tbl[9]  = mk(0,0,1, 3,10, 1,0,1,  0,3,0,  1,3,32'h77, 0, 1,0,0, 0,0,0,0);
    tbl[10] = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 1,   1,1,1, 3,1,32'h77,10);
    tbl[11] = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 0,   1,0,0, 0,0,0,0);
    tbl[12] = mk(0,0,1, 4,11, 1,0,2,  1,0,3,  0,0,0, 0,   1,0,0, 0,0,0,0);
    tbl[13] = mk(1,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 0,   1,1,1, 4,2,3,11);
    tbl[14] = mk(0,0,0, 0, 0, 0,0,0,  0,0,0,  0,0,0, 0,   1,0,0, 0,0,0,0);

    // Reset
    set_idle();
    rst = 1;
    @(negedge clk);
    cycle(0);
    cycle(0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      set_idle();
      rst = tbl[i].rs; flush = tbl[i].fl;
      if (tbl[i].av) drive_alloc(tbl[i].op, tbl[i].tg, tbl[i].r1, tbl[i].t1, tbl[i].v1,
                                 tbl[i].r2, tbl[i].t2, tbl[i].v2);
      cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
      issue_ready = tbl[i].ir;
      #1;
      chk($sformatf("vec%0d_alloc_ready", i), 64'(alloc_ready), 64'(tbl[i].e_ar));
      chk($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("vec%0d_issue_valid", i), 64'(issue_valid), 64'(tbl[i].e_iv));
      chk($sformatf("vec%0d_issue_alu_op", i), 64'(issue_alu_op), 64'(tbl[i].e_op));
      chk($sformatf("vec%0d_issue_op_a", i), 64'(issue_op_a), 64'(tbl[i].e_a));
      chk($sformatf("vec%0d_issue_op_b", i), 64'(issue_op_b), 64'(tbl[i].e_b));
      chk($sformatf("vec%0d_issue_rob_tag", i), 64'(issue_rob_tag), 64'(tbl[i].e_tag));
      cycle(0);
    end

    // Fill to capacity, ignore a 9th alloc, then free one slot by wakeup + issue
    set_idle();
    for (int k = 0; k < RS_SIZE; k++) begin
      drive_alloc(4'(k), TW'(16 + k), 0, TW'(20 + k), 0, 1, 0, XLEN'(k));
      issue_ready = 1;
      cycle(1);
    end
    drive_alloc(4'(9), 40, 1, 0, 32'h1234, 1, 0, 32'h5678);
    #1;
    chk("full_occupancy", 64'(occupancy), 64'(RS_SIZE));
    chk("full_alloc_ready", 64'(alloc_ready), 64'(0));
    cycle(1);
    #1;
    chk("full_ignored_occupancy", 64'(occupancy), 64'(RS_SIZE));
    cdb_valid = 1; cdb_tag = 23; cdb_value = 32'hABCD;
    accepted = 0;
    for (int k = 0; k < 6 && !accepted; k++) begin
      #1;
      accepted = alloc_ready && alloc_valid;
      cycle(1);
      cdb_valid = 0;
    end
    chk("full_pending_accepted", 64'(accepted), 64'(1));
    alloc_valid = 0;
    issue_ready = 0;
    #1;
    chk("full_refilled_occupancy", 64'(occupancy), 64'(RS_SIZE));
    cycle(1);

    // Flush with four waiting entries, concurrent alloc and issue_ready
    set_idle();
    flush = 1;
    cycle(1);
    flush = 0;
    for (int k = 0; k < 4; k++) begin
      drive_alloc(4'(k), TW'(k + 1), 0, 30, 0, 1, 0, 0);
      cycle(1);
    end
    drive_alloc(4'(5), 12, 1, 0, 1, 1, 0, 2);
    flush = 1;
    issue_ready = 1;
    #1;
    hs = issue_valid && issue_ready;
    chk("flush_no_handshake", 64'(hs), 64'(0));
    chk("flush_pre_occupancy", 64'(occupancy), 64'(4));
    cycle(1);
    set_idle();
    #1;
    chk("flush_occupancy", 64'(occupancy), 64'(0));
    chk("flush_issue_valid", 64'(issue_valid), 64'(0));
    chk("flush_alloc_ready", 64'(alloc_ready), 64'(1));
    cycle(1);

    // Streaming: three ready entries, then issue and allocate every cycle
    for (int k = 0; k < 3; k++) begin
      drive_alloc(4'(k), TW'(4 + k), 1, 0, XLEN'(k), 1, 0, XLEN'(k));
      cycle(1);
    end
    got.delete();
    for (int k = 0; k < 3; k++) begin
      drive_alloc(4'(k + 3), TW'(7 + k), 1, 0, XLEN'(k), 1, 0, XLEN'(k));
      issue_ready = 1;
      #1;
      chk($sformatf("stream_occupancy%0d", k), 64'(occupancy), 64'(3));
      if (issue_valid && issue_ready) got.push_back(issue_rob_tag);
      cycle(1);
    end
    set_idle();
    issue_ready = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (issue_valid && issue_ready) got.push_back(issue_rob_tag);
      cycle(1);
    end
    chk("stream_count", 64'(got.size()), 64'(6));
    for (int k = 0; k < got.size() && k < 6; k++) begin
      chk($sformatf("stream_order%0d", k), 64'(got[k]), 64'(4 + k));
    end

    // Randomized run against the reference model
    n = 0;
    while (n < 3000) begin
      set_idle();
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 49) == 0);
      alloc_valid = ($urandom_range(0, 9) < 7);
      alloc_alu_op = 4'($urandom);
      alloc_rob_tag = TW'($urandom);
      alloc_src1_rdy = $urandom_range(0, 1) == 1;
      alloc_src2_rdy = $urandom_range(0, 1) == 1;
      alloc_src1_tag = TW'($urandom_range(0, 7));
      alloc_src2_tag = TW'($urandom_range(0, 7));
      alloc_src1_val = $urandom;
      alloc_src2_val = $urandom;
      alloc_imm = $urandom;
      alloc_use_imm = ($urandom_range(0, 3) == 0);
      cdb_valid = ($urandom_range(0, 9) < 4);
      cdb_tag = TW'($urandom_range(0, 7));
      cdb_value = $urandom;
      issue_ready = ($urandom_range(0, 9) < 6);
      cycle(1);
      n++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- ALU reservation station directly downstream of the dispatch stage.
- Accepts one renamed ALU/branch instruction per cycle, holds it until both source operands are valid, and snoops the common data bus (CDB) for producer ROB tags.
- Issues the oldest ready entry to the integer ALU, one per cycle.
- Implemented as an age-ordered collapsing queue: entry 0 is always the oldest.

Parameters:
XLEN, 32, datapath width
RS_SIZE, 8, number of entries (>=2)
ROB_TAG_W, 6, ROB tag width
CNT_W, $clog2(RS_SIZE+1), occupancy counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  pipeline flush; clears all entries
alloc_valid  input  1  dispatch presents an instruction
alloc_ready  output  1  free entry available (count < RS_SIZE)
alloc_alu_op  input  4  ALU opcode
alloc_rob_tag  input  ROB_TAG_W  destination ROB tag
alloc_src1_rdy / alloc_src2_rdy  input  1 each  source value already valid
alloc_src1_tag / alloc_src2_tag  input  ROB_TAG_W each  producer tag when not ready
alloc_src1_val / alloc_src2_val  input  XLEN each  source value when ready
alloc_imm  input  XLEN  sign-extended immediate
alloc_use_imm  input  1  operand B = imm; src2 treated as ready
cdb_valid  input  1  result broadcast valid
cdb_tag  input  ROB_TAG_W  broadcast ROB tag
cdb_value  input  XLEN  broadcast value
issue_valid  output  1  an entry is ready to issue
issue_ready  input  1  ALU accepts
issue_alu_op  output  4  opcode of selected entry
issue_op_a / issue_op_b  output  XLEN each  operands
issue_rob_tag  output  ROB_TAG_W  tag of selected entry
occupancy  output  CNT_W  valid entry count

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. On reset, all entry valid bits = 0, occupancy = 0, alloc_ready = 1, issue_valid = 0, and all issue data outputs = 0.
- Entry state: valid, op, rob_tag, rdy1/tag1/val1, rdy2/tag2/val2. Valid entries always occupy indices 0..occupancy-1, in age order.
- Allocation: fires when alloc_valid && alloc_ready && !flush. The entry is written at index (occupancy - issued_this_cycle). With alloc_use_imm, val2 = alloc_imm and rdy2 = 1.
- Same-cycle CDB capture on allocation: if cdb_valid and an incoming not-ready tag equals cdb_tag, the entry is written ready with cdb_value. Both sources may match.
- alloc_ready = (occupancy < RS_SIZE). It does not anticipate a same-cycle issue. When full, alloc_valid is ignored.
- Wakeup: each cycle, every valid entry with rdyN = 0 and tagN == cdb_tag (cdb_valid = 1) sets rdyN = 1 and valN = cdb_value.
- Select: issue_valid = OR over valid entries with rdy1 && rdy2. The selected entry is the lowest index (oldest) ready one. issue_* outputs are combinational from that entry; when issue_valid = 0 they are 0.
- Issue handshake: fires when issue_valid && issue_ready. The selected entry is removed and all higher entries shift down by one at the clock edge. The wakeups of shifted entries are applied in the same edge.
- Latency: an instruction allocated ready in cycle N shows issue_valid in N+1. An entry woken by CDB in cycle N can issue no earlier than N+1 (see feature).
- Simultaneous alloc + issue: occupancy is unchanged; the new entry lands at the top slot after the collapse.
- Flush: all entries are invalidated at the next edge and occupancy = 0. Allocation and issue in the flush cycle are discarded; issue_ready is still honoured externally, but the RS drops its own state regardless. Flush has priority over alloc, issue and wakeup.
- Reset mid-operation behaves as flush and additionally zeros entry payloads.
- occupancy never exceeds RS_SIZE and never underflows.

Optional Feature:
- Macro: ALU_RS_WAKEUP_ISSUE_EN.
- Defined: select also treats as ready an operand whose tag matches cdb_tag while cdb_valid is high in the current cycle, and forwards cdb_value combinationally onto issue_op_a/issue_op_b. A woken entry can therefore issue in the same cycle as the broadcast; the oldest-first rule still applies.
- Undefined: readiness comes from registered rdy bits only, and woken entries issue one cycle later.

Test Plan:
- Reset, then alloc op=ADD, tag=5, src1=10 ready, src2=20 ready at cycle 1 -> cycle 2: issue_valid=1, op_a=10, op_b=20, rob_tag=5; with issue_ready=1, occupancy returns 0 at cycle 3.
- Alloc tag=1 with src1 waiting on tag 9, then tag=2 fully ready; hold issue_ready=1 -> tag 2 issues first; CDB tag=9 value=0x55 -> next cycle tag 1 issues with op_a=0x55 (same cycle as CDB if ALU_RS_WAKEUP_ISSUE_EN).
- Alloc 8 entries with no wakeups -> alloc_ready=0 and occupancy=8; a 9th alloc_valid is ignored. Broadcast one matching tag and issue it while alloc_valid=1 -> occupancy stays 8 for one cycle, then accepts the pending alloc.
- Alloc with src2 tag=3 in the same cycle as cdb_valid tag=3 value=0x77 -> entry captured ready; issues next cycle with op_b=0x77.
- Four valid entries, assert flush together with alloc_valid and issue_ready -> next cycle occupancy=0, issue_valid=0, alloc_ready=1, no issue handshake counted.
- Fill 3 entries, all ready (tags 4, 5, 6), issue_ready=1 while allocating tag 7 each cycle -> issue order 4, 5, 6, 7 and occupancy constant at 3 until allocation stops.
